payload_engine_ctrl: RTL and testbench
======================================

Name: payload_engine_ctrl

Overview:
- Sequences one packet payload at a time into a bank of NUM_ENGINES regex payload engines.
- Drives the engines' shared char bus, `en` and `sod` lines, flushes the engine pipeline at end of packet, then captures the per-engine match vector.
- Sits between the packet byte stream and the result/alert logic. Results leave on a valid/ready handshake.

Parameters:
- NUM_ENGINES, 16, number of engine match lines.
- MAX_LEN, 1518, payload bytes fed to engines; later bytes are consumed but not fed.
- ENG_LAT, 2, flush cycles needed for the last byte to reach the engines' sticky end state.
- LEN_W, 16, width of the length counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_data  in  8  payload byte
- s_valid  in  1  byte valid
- s_sop  in  1  first byte of packet
- s_eop  in  1  last byte of packet
- s_ready  out  1  byte accepted when s_valid&s_ready
- eng_char  out  8  byte to the char-class decoder
- eng_null  out  1  forces every decoder class line low
- eng_en  out  1  engine clock enable
- eng_sod  out  1  engine clear, active-high
- eng_match  in  NUM_ENGINES  engine `out` lines
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_match  out  NUM_ENGINES  captured match vector
- res_len  out  LEN_W  bytes accepted, saturating
- res_trunc  out  1  packet exceeded MAX_LEN
- res_abort  out  1  packet ended by a new s_sop instead of s_eop

Behaviour:
- Reset values:
  - eng_sod=1.
  - All other outputs 0.
  - FSM in IDLE, counters 0.
  - Reset asserted mid-packet aborts silently: no result is produced.
- FSM states: IDLE, STREAM, DRAIN, REPORT.
- IDLE:
  - s_ready=0, eng_sod=1, eng_en=0.
  - On s_valid&s_sop, go to STREAM; the sop beat is not consumed in IDLE.
  - A beat with s_valid and no s_sop in IDLE is stalled, never dropped.
- STREAM:
  - eng_sod=0.
  - s_ready=1 except combinationally 0 when s_valid&s_sop and len!=0.
  - Each accepted beat: registered eng_char=s_data, eng_null=0, and eng_en=1 the next cycle (latency 1) if len<MAX_LEN.
  - len increments per accepted beat, saturating at 2^LEN_W-1.
  - Accepting a beat at len>=MAX_LEN sets trunc and drives eng_en=0.
  - Accepted beat with s_eop: go to DRAIN.
  - s_valid&s_sop with len!=0: set abort and go to DRAIN; that sop beat is left for IDLE.
  - Bubbles (s_valid=0): eng_en=0, so engine state is held.
- DRAIN:
  - eng_en=1 and eng_null=1 for exactly ENG_LAT cycles, counted by a down-counter, so the sticky end states latch.
  - Then register res_match=eng_match, res_len, res_trunc, res_abort, and go to REPORT.
- REPORT:
  - res_valid=1 and eng_en=0; outputs stable while res_valid&!res_ready.
  - On res_ready: res_valid=0 next cycle, clear len/trunc/abort, go to IDLE (eng_sod=1 next cycle).
- Minimum gap: one IDLE cycle between packets guarantees eng_sod clears the engines before the next packet.
- Single-byte packet (sop&eop on the same beat): handled as a normal packet, res_len=1.
- res_ready asserted while res_valid=0: ignored.

Optional Feature:
- Macro: PAYLOAD_CTRL_STATS_EN.
- When defined, adds outputs:
  - stat_pkts (32): increments on each REPORT handshake.
  - stat_hits (32): increments when a handshaken res_match is non-zero.
  - stat_clr (1): input, synchronous clear.
- Both counters wrap at 2^32 and reset to 0 on rst_n.
- When undefined: no such ports and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package payload_ctrl_pkg holds:
  - FSM state enum (IDLE/STREAM/DRAIN/REPORT).
  - Default constants for MAX_LEN and ENG_LAT.
  - Result struct {match, len, trunc, abort}.
- One natural sub-module, payload_ctrl_result_reg: captures the result struct and owns the REPORT valid/ready hold logic.

Test Plan:
- 5-byte packet "ab/.." (sop on byte0, eop on byte4), no stalls -> eng_en high 5 cycles with eng_char following s_data one cycle late, then 2 null cycles; res_len=5, res_trunc=0, res_abort=0.
- Byte stream containing a full match sequence for engine 3 -> res_match=16'h0008. Same packet with res_ready held low 10 cycles -> res_valid stays high, s_ready=0 throughout, no new packet accepted.
- MAX_LEN=4, 7-byte packet -> eng_en pulses only for bytes 0-3; res_len=7, res_trunc=1.
- sop after 3 bytes with no eop -> res_abort=1, res_len=3; the sop beat is then accepted as byte 0 of the next packet, whose res_len is counted correctly.
- Single-byte sop&eop packet followed back-to-back by another packet -> two results; eng_sod high at least one cycle between them; res_len=1 for the first.
- rst_n pulsed low mid-STREAM -> eng_sod=1 immediately; res_valid never asserts; the next clean packet produces a correct result.

Source files
------------

// File: rtl/payload_ctrl_pkg.sv
// payload_ctrl_pkg: shared FSM states, default sizing and the result record
// used by payload_engine_ctrl and its result register.
package payload_ctrl_pkg;
  localparam int NUM_ENGINES_DEF = 16;
  localparam int LEN_W_DEF       = 16;
  localparam int MAX_LEN_DEF     = 1518;
  localparam int ENG_LAT_DEF     = 2;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, REPORT} state_t;
  // Field widths follow the package defaults; the top's NUM_ENGINES/LEN_W must match them.
  typedef struct packed {
    logic [NUM_ENGINES_DEF-1:0] match;
    logic [LEN_W_DEF-1:0]       len;
    logic                       trunc;
    logic                       abort;
  } res_t;
endpackage

// File: rtl/payload_ctrl_result_reg.sv
// payload_ctrl_result_reg: captures one packet result and holds it until the
// valid/ready handshake completes.
module payload_ctrl_result_reg
  import payload_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic cap,
  input  res_t res_in,
  input  logic res_ready,
  output logic res_valid,
  output res_t res,
  output logic done
);
  logic valid_q, valid_d;
  res_t res_q, res_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
    end
  always_comb begin
    done    = valid_q && res_ready;
    valid_d = cap || (valid_q && !res_ready);
    res_d   = cap ? res_in : res_q;
  end
  assign res_valid = valid_q;
  assign res       = res_q;
endmodule

// File: rtl/payload_engine_ctrl.sv
// payload_engine_ctrl: streams one packet payload into a regex engine bank, flushes it and
// reports the match vector; define PAYLOAD_CTRL_STATS_EN for packet/hit counters.
module payload_engine_ctrl
  import payload_ctrl_pkg::*;
#(
  parameter int NUM_ENGINES = NUM_ENGINES_DEF,
  parameter int MAX_LEN     = MAX_LEN_DEF,
  parameter int ENG_LAT     = ENG_LAT_DEF,
  parameter int LEN_W       = LEN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  input  logic                   s_sop,
  input  logic                   s_eop,
  output logic                   s_ready,
  output logic [7:0]             eng_char,
  output logic                   eng_null,
  output logic                   eng_en,
  output logic                   eng_sod,
  input  logic [NUM_ENGINES-1:0] eng_match,
`ifdef PAYLOAD_CTRL_STATS_EN
  input  logic                   stat_clr,
  output logic [31:0]            stat_pkts,
  output logic [31:0]            stat_hits,
`endif
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [NUM_ENGINES-1:0] res_match,
  output logic [LEN_W-1:0]       res_len,
  output logic                   res_trunc,
  output logic                   res_abort
);
  localparam int CNT_W = $clog2(ENG_LAT + 2);
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] char_q, char_d;
  logic trunc_q, trunc_d, abort_q, abort_d, en_q, en_d, null_q, null_d;
  logic accept, cap, done;
  res_t res_in, res;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      char_q  <= '0;
      trunc_q <= 1'b0;
      abort_q <= 1'b0;
      en_q    <= 1'b0;
      null_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      trunc_q <= trunc_d;
      abort_q <= abort_d;
      en_q    <= en_d;
      null_q  <= null_d;
    end
  // A new sop only enters once the previous packet has been reported and len cleared.
  always_comb begin
    s_ready = (state_q == STREAM) && !(s_valid && s_sop && len_q != '0);
    eng_sod = state_q == IDLE;
    accept  = s_valid && s_ready;
  end
  // DRAIN counts ENG_LAT+1 down to 0: ENG_LAT null strobes, one cycle for the last
  // strobe to be clocked into the engines, then capture.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    trunc_d = trunc_q;
    abort_d = abort_q;
    en_d    = 1'b0;
    null_d  = 1'b0;
    cap     = 1'b0;
    case (state_q)
      IDLE: state_d = (s_valid && s_sop) ? STREAM : IDLE;
      STREAM:
        if (accept) begin
          char_d  = s_data;
          en_d    = len_q < LEN_W'(MAX_LEN);
          trunc_d = trunc_q || (len_q >= LEN_W'(MAX_LEN));
          len_d   = (&len_q) ? len_q : len_q + LEN_W'(1);
          state_d = s_eop ? DRAIN : STREAM;
          cnt_d   = CNT_W'(ENG_LAT + 1);
        end else if (s_valid && s_sop) begin
          abort_d = 1'b1;
          state_d = DRAIN;
          cnt_d   = CNT_W'(ENG_LAT + 1);
        end
      DRAIN: begin
        en_d    = cnt_q > CNT_W'(1);
        null_d  = cnt_q > CNT_W'(1);
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        cap     = cnt_q == '0;
        state_d = (cnt_q == '0) ? REPORT : DRAIN;
      end
      default:
        if (done) begin
          state_d = IDLE;
          len_d   = '0;
          trunc_d = 1'b0;
          abort_d = 1'b0;
        end
    endcase
  end
  assign res_in = '{match: eng_match, len: len_q, trunc: trunc_q, abort: abort_q};
  payload_ctrl_result_reg u_res (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap       (cap),
    .res_in    (res_in),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res       (res),
    .done      (done)
  );
  assign eng_char  = char_q;
  assign eng_en    = en_q;
  assign eng_null  = null_q;
  assign res_match = res.match;
  assign res_len   = res.len;
  assign res_trunc = res.trunc;
  assign res_abort = res.abort;
`ifdef PAYLOAD_CTRL_STATS_EN
  logic [31:0] pkts_q, pkts_d, hits_q, hits_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pkts_q <= '0;
      hits_q <= '0;
    end else begin
      pkts_q <= pkts_d;
      hits_q <= hits_d;
    end
  always_comb begin
    pkts_d = stat_clr ? '0 : pkts_q + 32'(done);
    hits_d = stat_clr ? '0 : hits_q + 32'(done && (|res.match));
  end
  assign stat_pkts = pkts_q;
  assign stat_hits = hits_q;
`endif
endmodule

// File: tb/tb_payload_engine_ctrl.sv
// tb_payload_engine_ctrl: two DUTs (default MAX_LEN and MAX_LEN=4) share one stimulus stream;
// a toy engine bank answers eng_match, results are checked against a packet-level model.
module tb_payload_engine_ctrl;
  localparam int NE = 16, LW = 16, LAT = 2, ML0 = 1518, ML1 = 4;
  typedef logic [7:0] bq_t[$];
  typedef struct packed {logic [NE-1:0] m; logic [LW-1:0] len; logic tr; logic ab;} res_s;
  typedef struct {string s; logic ab; logic [NE-1:0] m0, m1; int len; logic tr0, tr1;} vec_t;

  logic clk = 0, rst_n = 0;
  logic [7:0] s_data = 0;
  logic s_valid = 0, s_sop = 0, s_eop = 0, res_ready = 0;
  logic s_ready[2], eng_null[2], eng_en[2], eng_sod[2], res_valid[2], res_trunc[2], res_abort[2];
  logic [7:0] eng_char[2];
  logic [NE-1:0] eng_match[2], res_match[2];
  logic [LW-1:0] res_len[2];
  int checks = 0, errors = 0;
  bit hold = 0, gaps = 0;
  res_s expq[2][$];
  logic [7:0] feedq[2][$];
  int fed[2], nul[2];
  bit sod_seen[2];
  res_s e;

  always #5 clk = ~clk;

  payload_engine_ctrl #(.MAX_LEN(ML0)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop),
    .s_ready(s_ready[0]), .eng_char(eng_char[0]), .eng_null(eng_null[0]), .eng_en(eng_en[0]),
    .eng_sod(eng_sod[0]), .eng_match(eng_match[0]), .res_valid(res_valid[0]), .res_ready(res_ready),
    .res_match(res_match[0]), .res_len(res_len[0]), .res_trunc(res_trunc[0]), .res_abort(res_abort[0]));
  payload_engine_ctrl #(.MAX_LEN(ML1)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop),
    .s_ready(s_ready[1]), .eng_char(eng_char[1]), .eng_null(eng_null[1]), .eng_en(eng_en[1]),
    .eng_sod(eng_sod[1]), .eng_match(eng_match[1]), .res_valid(res_valid[1]), .res_ready(res_ready),
    .res_match(res_match[1]), .res_len(res_len[1]), .res_trunc(res_trunc[1]), .res_abort(res_abort[1]));

  // Toy engine bank: LAT-deep pipeline, engine i sticks high after fed bytes "#" then 'A'+i.
  logic [8:0] pipe[2][LAT];
  logic [7:0] prev[2];
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (eng_sod[k]) begin
        eng_match[k] <= '0;
        prev[k] <= '0;
        for (int j = 0; j < LAT; j++) pipe[k][j] <= '0;
      end else if (eng_en[k]) begin
        if (pipe[k][LAT-1][8]) begin
          if (prev[k] == 8'h23 && pipe[k][LAT-1][7:0] >= 8'h41 && pipe[k][LAT-1][7:0] <= 8'h50)
            eng_match[k][pipe[k][LAT-1][3:0] - 4'h1] <= 1'b1;
          prev[k] <= pipe[k][LAT-1][7:0];
        end
        pipe[k][0] <= {!eng_null[k], eng_char[k]};
        for (int j = 1; j < LAT; j++) pipe[k][j] <= pipe[k][j-1];
      end

  function automatic int ml(int k);
    return k == 0 ? ML0 : ML1;
  endfunction

  function automatic res_s model(bq_t b, int maxl, logic ab);
    res_s r;
    r.len = (b.size() > 65535) ? 16'hffff : LW'(b.size());
    r.tr = b.size() > maxl;
    r.ab = ab;
    r.m = '0;
    for (int j = 1; j < b.size() && j < maxl; j++)
      if (b[j-1] == 8'h23 && b[j] >= 8'h41 && b[j] <= 8'h50) r.m[b[j] - 8'h41] = 1'b1;
    return r;
  endfunction

  function automatic bq_t s2q(string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic logic [7:0] rb();
    int r = $urandom % 4;
    return r == 0 ? 8'h23 : r < 3 ? 8'(8'h41 + $urandom % 16) : 8'($urandom);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic sop, input logic eop);
    int t = 0;
    if (gaps && $urandom % 4 == 0) begin
      s_valid = 0;
      @(posedge clk); #1;
    end
    s_data = d; s_sop = sop; s_eop = eop; s_valid = 1;
    @(negedge clk);
    while (!s_ready[0] && t < 200) begin t++; @(negedge clk); end
    if (t >= 200) chk("beat_timeout", 1, 0);
    @(posedge clk); #1 s_valid = 0;
  endtask

  task automatic send(input bq_t b, input logic ab, input res_s e0, input res_s e1);
    expq[0].push_back(e0);
    expq[1].push_back(e1);
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < b.size() && j < ml(k); j++) feedq[k].push_back(b[j]);
    for (int j = 0; j < b.size(); j++) beat(b[j], j == 0, (j == b.size() - 1) && !ab);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((expq[0].size() != 0 || expq[1].size() != 0) && t < 1000) begin t++; @(negedge clk); end
    chk("results_drained", t < 1000, 1);
  endtask

  always #5 if (clk == 1'b0) ;

  always @(negedge clk)
    for (int k = 0; k < 2; k++)
      if (!rst_n) begin
        feedq[k].delete();
        fed[k] = 0; nul[k] = 0; sod_seen[k] = 1;
      end else begin
        if (eng_sod[k]) begin
          sod_seen[k] = 1;
          chk($sformatf("en_in_idle%0d", k), eng_en[k], 0);
        end
        if (eng_en[k] && eng_null[k]) nul[k]++;
        if (eng_en[k] && !eng_null[k]) begin
          if (feedq[k].size() == 0) chk($sformatf("feed_extra%0d", k), 1, 0);
          else chk($sformatf("eng_char%0d", k), eng_char[k], feedq[k].pop_front());
          fed[k]++;
        end
        if (res_valid[k] && res_ready) begin
          if (expq[k].size() == 0) chk($sformatf("spurious_result%0d", k), 1, 0);
          else begin
            e = expq[k].pop_front();
            chk($sformatf("res_match%0d", k), res_match[k], e.m);
            chk($sformatf("res_len%0d", k), res_len[k], e.len);
            chk($sformatf("res_trunc%0d", k), res_trunc[k], e.tr);
            chk($sformatf("res_abort%0d", k), res_abort[k], e.ab);
            chk($sformatf("fed_count%0d", k), fed[k], (int'(e.len) < ml(k)) ? int'(e.len) : ml(k));
            chk($sformatf("null_count%0d", k), nul[k], LAT);
            chk($sformatf("sod_between%0d", k), sod_seen[k], 1);
          end
          fed[k] = 0; nul[k] = 0; sod_seen[k] = 0;
        end
      end

  initial forever begin
    @(posedge clk); #1;
    res_ready = !hold && ($urandom % 4 != 0);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t tbl[8];
  initial begin
    tbl[0] = '{"ab/..",   0, 16'h0000, 16'h0000, 5, 0, 1};
    tbl[1] = '{"x#Dyz",   0, 16'h0008, 16'h0008, 5, 0, 1};
    tbl[2] = '{"1234567", 0, 16'h0000, 16'h0000, 7, 0, 1};
    tbl[3] = '{"abcd#Az", 0, 16'h0001, 16'h0000, 7, 0, 1};
    tbl[4] = '{"#",       0, 16'h0000, 16'h0000, 1, 0, 0};
    tbl[5] = '{"#Pq",     1, 16'h8000, 16'h8000, 3, 0, 0};
    tbl[6] = '{"xy",      0, 16'h0000, 16'h0000, 2, 0, 0};
    tbl[7] = '{"#B#C",    0, 16'h0006, 16'h0006, 4, 0, 0};
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_sod%0d", k), eng_sod[k], 1);
      chk($sformatf("rst_ready%0d", k), s_ready[k], 0);
      chk($sformatf("rst_en%0d", k), eng_en[k], 0);
      chk($sformatf("rst_null%0d", k), eng_null[k], 0);
      chk($sformatf("rst_char%0d", k), eng_char[k], 0);
      chk($sformatf("rst_valid%0d", k), res_valid[k], 0);
      chk($sformatf("rst_res%0d", k), {res_match[k], res_len[k], res_trunc[k], res_abort[k]}, 0);
    end
    @(posedge clk); #1 rst_n = 1;
    s_data = 8'h55; s_sop = 0; s_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_stall_ready", s_ready[0], 0);
      chk("idle_stall_sod", eng_sod[0], 1);
    end
    @(posedge clk); #1 s_valid = 0;
    for (int i = 0; i < 8; i++)
      send(s2q(tbl[i].s), tbl[i].ab,
           '{m: tbl[i].m0, len: LW'(tbl[i].len), tr: tbl[i].tr0, ab: tbl[i].ab},
           '{m: tbl[i].m1, len: LW'(tbl[i].len), tr: tbl[i].tr1, ab: tbl[i].ab});
    // Result held while res_ready stays low; the next sop waits.
    wait_idle();
    hold = 1;
    send(s2q("q#Dr"), 0, '{16'h0008, 16'd4, 1'b0, 1'b0}, '{16'h0008, 16'd4, 1'b0, 1'b0});
    s_data = 8'h7a; s_sop = 1; s_eop = 0; s_valid = 1;
    for (int t = 0; t < 50 && !res_valid[0]; t++) @(negedge clk);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("hold_valid", {res_valid[0], res_valid[1]}, 2'b11);
      chk("hold_ready", s_ready[0], 0);
      chk("hold_match", res_match[0], 16'h0008);
      chk("hold_len", res_len[0], 4);
    end
    hold = 0;
    send(s2q("zz"), 0, '{16'h0000, 16'd2, 1'b0, 1'b0}, '{16'h0000, 16'd2, 1'b0, 1'b0});
    // Reset mid-packet: no result, engines cleared at once.
    wait_idle();
    for (int k = 0; k < 2; k++) begin feedq[k].push_back(8'h23); feedq[k].push_back(8'h41); end
    beat(8'h23, 1, 0);
    beat(8'h41, 0, 0);
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midrst_sod%0d", k), eng_sod[k], 1);
      chk($sformatf("midrst_valid%0d", k), res_valid[k], 0);
      chk($sformatf("midrst_en%0d", k), eng_en[k], 0);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1;
    send(s2q("#K"), 0, '{16'h0400, 16'd2, 1'b0, 1'b0}, '{16'h0400, 16'd2, 1'b0, 1'b0});
    gaps = 1;
    for (int p = 0; p < 40; p++) begin
      bq_t b;
      int n;
      logic ab;
      b.delete();
      n = $urandom_range(1, 9);
      ab = (p < 39) && ($urandom % 5 == 0);
      for (int i = 0; i < n; i++) b.push_back(rb());
      send(b, ab, model(b, ML0, ab), model(b, ML1, ab));
    end
    wait_idle();
    chk("feed_left0", feedq[0].size(), 0);
    chk("feed_left1", feedq[1].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
